// File: rtl/agc_ratio_req.sv
// agc_ratio_req: per-block peak magnitude tracker issuing setpoint/peak divide requests
module agc_ratio_req #(
  parameter int LOG2N = 8,
  parameter int TMO   = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sin,
  input  logic        sv,
  input  logic [15:0] sref,
  output logic [15:0] aout,
  output logic [15:0] bout,
  output logic        iv,
  input  logic        ov,
  output logic        busy,
  output logic        drop,
  output logic        err
);
  localparam int TW = $clog2(TMO + 1);
  typedef enum logic [1:0] {HOLD, IDLE, ISSUE, WAIT} state_t;
  state_t state_q;
  logic [TW-1:0] tmr_q;
  logic [LOG2N-1:0] cnt_q;
  logic [14:0] peak_q, blk_peak_q, mag, pk;
  logic [15:0] neg;
  logic pend_q, blk_end;
  always_comb begin
    neg = -sin;
    mag = (sin == 16'h8000) ? 15'h7fff : sin[15] ? neg[14:0] : sin[14:0];
    pk = (mag > peak_q) ? mag : peak_q;
    blk_end = sv && (cnt_q == {LOG2N{1'b1}});
  end
  // tmr_q serves as the holdoff counter in HOLD and the ov timeout in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      tmr_q <= TW'(TMO);
      cnt_q <= '0;
      peak_q <= '0;
      blk_peak_q <= '0;
      pend_q <= 1'b0;
      aout <= '0;
      bout <= '0;
      iv <= 1'b0;
      busy <= 1'b0;
      drop <= 1'b0;
      err <= 1'b0;
    end else begin
      iv <= 1'b0;
      err <= 1'b0;
      drop <= blk_end & pend_q;
      pend_q <= blk_end | (pend_q & (state_q != ISSUE));
      if (sv) begin
        cnt_q <= cnt_q + 1'b1;
        peak_q <= blk_end ? '0 : pk;
        if (blk_end) blk_peak_q <= pk;
      end
      case (state_q)
        HOLD: begin
          if (tmr_q == '0) state_q <= IDLE;
          else tmr_q <= tmr_q - 1'b1;
        end
        IDLE: if (pend_q) state_q <= ISSUE;
        ISSUE: begin
          iv <= 1'b1;
          aout <= sref;
          bout <= (blk_peak_q == '0) ? 16'h0001 : {1'b0, blk_peak_q};
          busy <= 1'b1;
          tmr_q <= TW'(TMO);
          state_q <= WAIT;
        end
        WAIT: begin
          // timeout compares against 1 so err lands exactly TMO cycles after iv
          if (ov || tmr_q == TW'(1)) begin
            err <= ~ov;
            busy <= 1'b0;
            state_q <= IDLE;
          end else tmr_q <= tmr_q - 1'b1;
        end
        default: state_q <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_agc_ratio_req.sv
// tb_agc_ratio_req: directed vectors plus a block-peak scoreboard checking every divide request
module tb_agc_ratio_req;
  logic clk = 1'b0, rst = 1'b1, sv = 1'b0, ov, iv, busy, drop, err;
  logic [15:0] sin = '0, sref = '0, aout, bout;
  always #5 clk = ~clk;
  agc_ratio_req #(.LOG2N(2), .TMO(40)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sv(sv), .sref(sref), .aout(aout), .bout(bout),
    .iv(iv), .ov(ov), .busy(busy), .drop(drop), .err(err)
  );
  // divider model: ov is high in the 33rd cycle after the iv cycle
  int cyc = 0, iv_cyc = -1000;
  logic div_en = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (iv) iv_cyc <= cyc;
  end
  assign ov = div_en && (cyc == iv_cyc + 33);
  int checks = 0, errors = 0, niv = 0, ndrop = 0, nerr = 0, m_cnt = 0;
  logic [14:0] m_max = '0, m_blk = '0;
  logic prev_busy = 1'b0;
  typedef struct {
    logic [63:0] s;
    logic [15:0] r;
    logic [15:0] b;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    logic s_sv, s_rst;
    logic [15:0] s_ref, ng;
    logic [14:0] s_mag;
    s_sv = sv;
    s_rst = rst;
    s_ref = sref;
    ng = -sin;
    s_mag = (sin == 16'h8000) ? 15'h7fff : sin[15] ? ng[14:0] : sin[14:0];
    @(posedge clk);
    #1;
    if (s_rst) begin
      m_max = '0;
      m_blk = '0;
      m_cnt = 0;
    end else begin
      if (iv) begin
        niv++;
        chk("iv_bout", 32'(bout), 32'((m_blk == '0) ? 16'h0001 : {1'b0, m_blk}));
        chk("iv_aout", 32'(aout), 32'(s_ref));
        chk("iv_while_busy", 32'(prev_busy), 32'd0);
      end
      if (s_sv) begin
        if (s_mag > m_max) m_max = s_mag;
        m_cnt++;
        if (m_cnt == 4) begin
          m_blk = m_max;
          m_max = '0;
          m_cnt = 0;
        end
      end
    end
    if (drop) ndrop++;
    if (err) nerr++;
    prev_busy = busy;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic send(input logic [63:0] s);
    for (int i = 0; i < 4; i++) begin
      sin = s[48-16*i +: 16];
      sv = 1'b1;
      step();
    end
    sv = 1'b0;
    sin = '0;
  endtask
  task automatic wait_iv(output int n);
    n = 0;
    while (!iv && n < 100) begin
      step();
      n++;
    end
  endtask
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, k, b0, d0, e0;
    tv[0] = '{{16'h1000, 16'h4000, 16'hF000, 16'h0100}, 16'h2000, 16'h4000};
    tv[1] = '{{16'h8000, 16'h0001, 16'h0002, 16'h0003}, 16'h3000, 16'h7FFF};
    tv[2] = '{{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h4000, 16'h0001};
    tv[3] = '{{16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001}, 16'h0123, 16'h0002};
    tv[4] = '{{16'h7FFF, 16'h8001, 16'h0000, 16'h0000}, 16'hFFFF, 16'h7FFF};
    tv[5] = '{{16'hC000, 16'h3FFF, 16'h0000, 16'h0000}, 16'h0800, 16'h4000};
    run(3);
    chk("rst_aout", 32'(aout), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ctl", 32'({iv, busy, drop, err}), 32'd0);
    rst = 1'b0;
    run(45);
    chk("holdoff_no_iv", 32'(niv), 32'd0);
    for (int i = 0; i < 6; i++) begin
      sref = tv[i].r;
      send(tv[i].s);
      wait_iv(n);
      if (i == 0) chk("latency", 32'(n), 32'd2);
      chk("tbl_aout", 32'(aout), 32'(tv[i].r));
      chk("tbl_bout", 32'(bout), 32'(tv[i].b));
      busy_len(n);
      chk("tbl_busy_len", 32'(n), 32'd34);
      run(3);
    end
    chk("tbl_no_drop", 32'(ndrop), 32'd0);
    // continuous samples while requests are in flight
    sref = 16'h1234;
    b0 = niv;
    d0 = ndrop;
    for (int j = 0; j < 100; j++) begin
      sin = 16'((j + 1) * 8);
      sv = 1'b1;
      step();
    end
    sv = 1'b0;
    sin = '0;
    run(120);
    chk("stream_ivs", 32'(niv - b0 >= 3), 32'd1);
    chk("stream_drop", 32'(ndrop > d0), 32'd1);
    // divider silent: timeout then the pending block issues
    div_en = 1'b0;
    e0 = nerr;
    sref = 16'h0800;
    send({16'h0200, 16'h0000, 16'h0000, 16'h0000});
    wait_iv(n);
    send({16'h0300, 16'h0000, 16'h0000, 16'h0000});
    k = 4;
    while (!err && k < 100) begin
      step();
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'd40);
    chk("tmo_busy", 32'(busy), 32'd0);
    div_en = 1'b1;
    wait_iv(n);
    chk("tmo_next_iv", 32'(n), 32'd2);
    chk("tmo_next_bout", 32'(bout), 32'h0300);
    busy_len(n);
    chk("tmo_next_busy", 32'(n), 32'd34);
    chk("tmo_errs", 32'(nerr - e0), 32'd1);
    run(3);
    // reset during WAIT with a partial block accumulated
    sref = 16'h1111;
    send({16'h0400, 16'h0000, 16'h0000, 16'h0000});
    wait_iv(n);
    run(5);
    sin = 16'h7000;
    sv = 1'b1;
    run(2);
    sv = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_rst_aout", 32'(aout), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    chk("mid_rst_ctl", 32'({iv, busy, drop, err}), 32'd0);
    rst = 1'b0;
    b0 = niv;
    send({16'h0100, 16'h0100, 16'h0100, 16'h0100});
    k = 4;
    while (!iv && k < 100) begin
      step();
      k++;
    end
    chk("rst_holdoff_iv", 32'(k), 32'd43);
    chk("rst_bout_new", 32'(bout), 32'h0100);
    run(45);
    chk("rst_one_iv", 32'(niv - b0), 32'd1);
    // block ending on the ISSUE edge keeps pend set
    sref = 16'h2222;
    send({16'h0010, 16'h0000, 16'h0000, 16'h0000});
    wait_iv(n);
    b0 = niv;
    for (int j = 1; j <= 40; j++) begin
      sv = (j >= 20 && j <= 23) || (j >= 33 && j <= 36);
      sin = (j >= 20 && j <= 23) ? 16'h0500 : (j >= 33 && j <= 36) ? 16'h0600 : 16'h0000;
      step();
      if (j == 36) begin
        chk("same_edge_iv", 32'(iv), 32'd1);
        chk("same_edge_bout", 32'(bout), 32'h0500);
      end
    end
    sv = 1'b0;
    sin = '0;
    wait_iv(n);
    chk("same_edge_next_bout", 32'(bout), 32'h0600);
    run(60);
    chk("same_edge_ivs", 32'(niv - b0), 32'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
